// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module   : serial_arith_pkg
// Brief    : State encodings and sizing helper shared by the serial arithmetic units.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    localparam int         c_STATE_W  = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module   : full_subtractor
// Brief    : One-bit combinational full subtractor: diff/bout of a - b - bin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign diff  = w_axb ^ bin;
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial, LSB-first WIDTH-bit subtractor (a - b - bin) with a
//            start/done handshake, built around a single full-subtractor cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int               c_CW   = cnt_width(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_d;
    logic                 r_brw;
    logic [c_CW-1:0]      r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_diff;
    logic                 r_bout;

    logic                 w_d;
    logic                 w_bn;

    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_brw),
        .diff (w_d),
        .bout (w_bn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_brw   <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    r_d   <= {w_d, r_d[WIDTH-1:1]};
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_brw <= w_bn;
                    // Counter holds at its last value so it never wraps mid-operation.
                    if (r_cnt == c_LAST) begin
                        r_diff  <= {w_d, r_d[WIDTH-1:1]};
                        r_bout  <= w_bn;
                        r_done  <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor (WIDTH=8) and its cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int c_W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           bin;
    logic           busy;
    logic           done;
    logic [c_W-1:0] diff;
    logic           bout;

    logic fs_a, fs_b, fs_bin, fs_diff, fs_bout;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vbin;
        logic [7:0] ed;
        logic       ebo;
    } vec_t;

    vec_t vecs[5];

    serial_subtractor #(.WIDTH(c_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    full_subtractor u_fs (
        .a    (fs_a),
        .b    (fs_b),
        .bin  (fs_bin),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, borrow-out is a negative result.
    function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        return {(r < 0), 8'(r & 255)};
    endfunction

    // Issue one operation from IDLE and check latency, result and done width.
    task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb, input logic vbin);
        logic [8:0] e;
        int k;
        e = ref_sub(va, vb, vbin);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; bin = vbin;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        check({name, " busy"}, {31'd0, busy}, 32'd1);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check({name, " latency"}, k, 32'd8);
        check({name, " diff"}, {24'd0, diff}, {24'd0, e[7:0]});
        check({name, " bout"}, {31'd0, bout}, {31'd0, e[8]});
        @(negedge clk);
        check({name, " done width"}, {31'd0, done}, 32'd0);
        check({name, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [8:0] e;
        logic [8:0] ops[64];
        int npulse;
        int k;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        fs_a = 1'b0; fs_b = 1'b0; fs_bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset diff", {24'd0, diff}, 32'd0);
        check("reset bout", {31'd0, bout}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            e = ref_sub(vecs[i].va, vecs[i].vb, vecs[i].vbin);
            check($sformatf("model vec%0d", i), {23'd0, e}, {23'd0, vecs[i].ebo, vecs[i].ed});
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vbin);
            check($sformatf("vec%0d table diff", i), {24'd0, diff}, {24'd0, vecs[i].ed});
            check($sformatf("vec%0d table bout", i), {31'd0, bout}, {31'd0, vecs[i].ebo});
        end

        // Start pulse during SHIFT must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h05; b = 8'h03; bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        npulse = 0;
        for (int t = 0; t < 20; t++) begin
            if (done === 1'b1) begin
                npulse++;
                check("busy-start diff", {24'd0, diff}, 32'h02);
            end
            @(negedge clk);
        end
        check("busy-start pulses", npulse, 32'd1);

        // Back-to-back: start held high, new operands every cycle.
        for (int t = 0; t < 42; t++) begin
            @(negedge clk);
            if (t > 0) begin
                check($sformatf("b2b done t=%0d", t), {31'd0, done}, {31'd0, (t % 10 == 9)});
                if (t % 10 == 9) begin
                    e = ref_sub(ops[t-9][8:1], ops[t-9][0] ? 8'h00 : 8'h00, 1'b0);
                    e = ops[t-9];
                    check($sformatf("b2b result t=%0d", t), {23'd0, diff, bout}, {23'd0, e});
                end
            end
            start = 1'b1; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            e = ref_sub(a, b, bin);
            ops[t] = {e[7:0], e[8]};
        end
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("b2b drain", {31'd0, busy}, 32'd0);

        // Reset mid-operation at cnt=4.
        run_op("pre-reset", 8'h5A, 8'h11, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 8'hC3; b = 8'h21; bin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst diff", {24'd0, diff}, 32'd0);
        check("midrst bout", {31'd0, bout}, 32'd0);
        npulse = 0;
        for (int t = 0; t < 12; t++) begin
            if (done === 1'b1) npulse++;
            @(negedge clk);
        end
        check("midrst no done", npulse, 32'd0);
        run_op("post-reset", 8'h3C, 8'h4D, 1'b1);

        for (int i = 0; i < 20; i++)
            run_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));

        // Exhaustive one-bit cell.
        for (int i = 0; i < 8; i++) begin
            int r;
            fs_a = i[2]; fs_b = i[1]; fs_bin = i[0];
            #1;
            r = int'(fs_a) - int'(fs_b) - int'(fs_bin);
            check($sformatf("cell %0d%0d%0d", fs_a, fs_b, fs_bin),
                  {30'd0, fs_bout, fs_diff}, {30'd0, (r < 0), 1'(r & 1)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
